mem_arbiter_rr: RTL
===================

// Module: mem_arbiter_rr
// PURPOSE
//  Parametrised successor to the two-port I/D memory arbitrator: N cache requesters share one
//  pipelined fixed-latency main memory. Read misses get a full block burst, writes are single-word
//  write-through. Fixed-priority or round-robin grant; one transaction owns memory until done.
//  Sits between the fetch/memory-stage caches (ch0 = icache, ch1 = dcache) and main memory.
// PARAMETERS
//  NUM_REQ      2   number of requester channels (>=2)
//  ADDR_W      16   byte address width
//  DATA_W      16   word width; words are 2-byte aligned, addresses step by 2
//  BURST_LEN    8   words per read burst (power of 2, >=1)
//  MEM_LATENCY  4   cycles from memory issue to read data (>=1)
//  ARB_MODE     1   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 asynchronous active-low reset
//  req        in   NUM_REQ           per-channel request level
//  wr         in   NUM_REQ           per-channel 1=write, 0=block read
//  addr       in   NUM_REQ*ADDR_W    per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//  wdata      in   NUM_REQ*DATA_W    per-channel write data
//  service    out  NUM_REQ           one-hot owner of memory; all 0 when idle
//  data_valid out  1                 rdata valid for the current owner
//  rdata      out  DATA_W            returned read word
//  rdata_addr out  ADDR_W            address of the returned word
//  done       out  1                 one-cycle pulse: owner's transaction complete
//  mem_en     out  1                 memory issue strobe
//  mem_wr     out  1                 issue is a write
//  mem_addr   out  ADDR_W            issue address
//  mem_wdata  out  DATA_W            issue write data
//  mem_rdata  in   DATA_W            memory read data, valid MEM_LATENCY cycles after a read issue
// BEHAVIOUR
//  Reset: state IDLE; service, data_valid, done, mem_en, mem_wr = 0; rdata, rdata_addr,
//   mem_addr, mem_wdata = 0; RR pointer = NUM_REQ-1 so ch0 wins the first contest.
//  States: IDLE -> READ | WRITE; READ -> DRAIN; DRAIN -> IDLE; WRITE -> IDLE.
//  IDLE: if any req, pick winner g (mode below); register service=onehot(g), latch wr[g],
//   addr[g], wdata[g]; move to WRITE if wr[g] else READ. No req: stay, all strobes 0.
//  READ: base = addr & ~(BURST_LEN*2-1); issue mem_en=1, mem_wr=0, mem_addr=base+2k for k=0..BURST_LEN-1
//   on consecutive cycles, first issue in the cycle service rises; after the last issue -> DRAIN.
//  Return: a MEM_LATENCY-deep valid/address pipeline; data_valid=1, rdata=mem_rdata,
//   rdata_addr=issued addr exactly MEM_LATENCY cycles after each issue. done=1 with the last
//   data_valid; DRAIN -> IDLE on that cycle (service drops the next cycle).
//  WRITE: single cycle mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched wdata,
//   done=1 same cycle; -> IDLE. No data_valid for writes.
//  Timing (read): req sampled in IDLE cycle t -> service/first issue t+1 -> last data_valid+done at
//   t+BURST_LEN+MEM_LATENCY; earliest next service at t+BURST_LEN+MEM_LATENCY+2.
//  Arbitration: fixed = lowest set index. RR = first set index scanning from ptr+1 mod NUM_REQ;
//   ptr <= g on each grant. Simultaneous reqs resolved only in IDLE; reqs arriving mid-transaction wait.
//  Owner dropping req mid-transaction: ignored, transaction completes, done still pulses.
//  Requesters must drop req in the cycle after done or be re-granted (RR rotates past them if others wait).
//  BURST_LEN=1: READ issues one word, DRAIN waits MEM_LATENCY. MEM_LATENCY=1: DRAIN lasts 1 cycle.
//  Address arithmetic mod 2^ADDR_W; burst never crosses the aligned block (base aligned).
//  Reset asserted mid-burst: immediate return to reset values; in-flight returns discarded.
// STRUCTURE
//  Package arb_pkg: state enum (IDLE, READ, WRITE, DRAIN), ARB_FIXED=0 / ARB_RR=1 constants.
//  Sub-module rr_pick: combinational winner select (req vector, pointer, mode) -> onehot + index.
//  Top holds FSM, issue counter, latency shift register (valid + addr), RR pointer.
// TESTING
//  Reset: rst_n=0 mid-burst -> all outputs 0 next edge, no further data_valid after release.
//  Single read ch0 addr=0x1236, defaults -> mem_addr 0x1230..0x123E on 8 cycles; data_valid 8 cycles
//   starting 4 after first issue; done on 8th valid; service=2'b01 throughout.
//  Write ch1 addr=0x0040 wdata=0xBEEF -> one cycle mem_en=1 mem_wr=1 0x0040/0xBEEF, done same cycle.
//  Both req held, ARB_MODE=1 -> grants alternate ch0,ch1,ch0; ARB_MODE=0 -> ch0 every time.
//  NUM_REQ=4, reqs 1 and 3 during ch0 burst -> after done: ch1 then ch3; none lost.
//  BURST_LEN=1, MEM_LATENCY=1: read 0x0010 -> one issue, data_valid+done next cycle, back to IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the N-way memory arbiter: FSM state encoding and arbitration modes.
package arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: lowest set index (fixed) or first set index after the pointer (RR).
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_mode,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    always_comb begin
        int               j;
        logic [IDX_W-1:0] w_j;
        logic             w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        j       = 0;
        w_j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j   = (i_mode == ARB_RR) ? (int'(i_ptr) + 1 + i) % NUM_REQ : i;
            w_j = IDX_W'(j);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_idx       = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
        o_any = w_found;
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// N-requester arbiter in front of a pipelined fixed-latency memory: block-burst reads,
// single-word write-through, one transaction owns memory until its done pulse.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 8,
    parameter int MEM_LATENCY = 4,
    parameter int ARB_MODE    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         wr,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         service,
    output logic                       data_valid,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          rdata_addr,
    output logic                       done,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BURST_LEN * 2 - 1);

    state_t                          r_state;
    logic [NUM_REQ-1:0]              r_service;
    logic [IDX_W-1:0]                r_ptr;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_mem_en, r_mem_wr, r_wdone;
    logic [ADDR_W-1:0]               r_mem_addr;
    logic [DATA_W-1:0]               r_mem_wdata;
    logic [MEM_LATENCY:1]            r_vld_pipe, r_last_pipe;
    logic [MEM_LATENCY:1][ADDR_W-1:0] r_addr_pipe;

    logic [NUM_REQ-1:0]              w_grant;
    logic [IDX_W-1:0]                w_idx;
    logic                            w_any;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  w_addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0]  w_wdata_v;
    logic                            w_issue_rd, w_issue_last, w_ret_last;

    assign w_addr_v  = addr;
    assign w_wdata_v = wdata;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_mode  ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_issue_rd   = r_mem_en & ~r_mem_wr;
    assign w_issue_last = (r_state == READ) && (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_ret_last   = r_vld_pipe[MEM_LATENCY] & r_last_pipe[MEM_LATENCY];

    // Strobes are registered: the first read issue goes out in the cycle service rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_service   <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_wdone     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_wdone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mem_en <= 1'b0;
                    r_mem_wr <= 1'b0;
                    if (w_any) begin
                        r_service <= w_grant;
                        r_ptr     <= w_idx;
                        r_cnt     <= '0;
                        r_mem_en  <= 1'b1;
                        if (wr[w_idx]) begin
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= w_addr_v[w_idx];
                            r_mem_wdata <= w_wdata_v[w_idx];
                            r_wdone     <= 1'b1;
                            r_state     <= WRITE;
                        end else begin
                            r_mem_addr <= w_addr_v[w_idx] & ~BLK_MASK;
                            r_state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                        r_mem_en <= 1'b0;
                        r_state  <= DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(2);
                    end
                end
                DRAIN: begin
                    if (w_ret_last) begin
                        r_service <= '0;
                        r_state   <= IDLE;
                    end
                end
                WRITE: begin
                    r_mem_en  <= 1'b0;
                    r_mem_wr  <= 1'b0;
                    r_service <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Return tracker mirrors the memory latency; the last flag marks the burst's final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_addr_pipe <= '0;
        end else begin
            r_vld_pipe[1]  <= w_issue_rd;
            r_last_pipe[1] <= w_issue_last;
            r_addr_pipe[1] <= r_mem_addr;
            for (int s = 2; s <= MEM_LATENCY; s++) begin
                r_vld_pipe[s]  <= r_vld_pipe[s-1];
                r_last_pipe[s] <= r_last_pipe[s-1];
                r_addr_pipe[s] <= r_addr_pipe[s-1];
            end
        end
    end

    assign service    = r_service;
    assign data_valid = r_vld_pipe[MEM_LATENCY];
    assign rdata      = data_valid ? mem_rdata : '0;
    assign rdata_addr = r_addr_pipe[MEM_LATENCY];
    assign done       = r_wdone | w_ret_last;
    assign mem_en     = r_mem_en;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
endmodule
